// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access controller with stall, alignment and timeout handling
module mem_access_unit #(
    parameter int data_size   = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemRead,
    input  logic                 M_MemWrite,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_Store_Data,
    output logic                 DM_req,
    output logic                 DM_we,
    output logic [data_size-1:0] DM_addr,
    output logic [data_size-1:0] DM_wdata,
    input  logic                 DM_ack,
    input  logic [data_size-1:0] DM_rdata,
    output logic [data_size-1:0] M_DM_Read_Data,
    output logic                 mem_stall,
    output logic                 M_WBWrite,
    output logic                 align_err,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [data_size-1:0] rdata_q, rdata_d;
    logic                 align_q, align_d;
    logic                 tout_q, tout_d;

    logic op;
    logic is_write;
    logic misaligned;
    logic timeout_hit;

    // A store takes priority when both MemRead and MemWrite are raised.
    assign op          = M_MemRead | M_MemWrite;
    assign is_write    = M_MemWrite;
    assign misaligned  = (M_ALU_result[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // State, timeout counter, load data and error flags; reset drops DM_req immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            align_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state, stall and request decode; error flags are armed only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        align_d   = 1'b0;
        tout_d    = 1'b0;
        DM_req    = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (op) begin
                    mem_stall = 1'b1;
                    if (misaligned) begin
                        state_d = DONE;
                        align_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                DM_req    = 1'b1;
                mem_stall = 1'b1;
                if (DM_ack) begin
                    state_d = DONE;
                    rdata_d = is_write ? '0 : DM_rdata;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    rdata_d = '0;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DM_we          = DM_req & is_write;
    assign DM_addr        = {M_ALU_result[data_size-1:2], 2'b00};
    assign DM_wdata       = M_Store_Data;
    assign M_DM_Read_Data = rdata_q;
    assign M_WBWrite      = ~mem_stall;
    assign align_err      = align_q;
    assign timeout_err    = tout_q;

endmodule
